// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable-period timer sequencer.
// Latches period/prescale/mode on an accepted start, then advances the main
// count once every (prescale+1) clocks. On the terminal step the count clears
// and a one-cycle tick is emitted; one-shot runs also pulse done and return
// to IDLE, periodic runs keep going until stopped.
// Optional feature macro: TIMER_CTRL_PAUSE_EN (adds pause_i, which freezes
// the prescaler and count while running).
module timer_ctrl #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      mode_i,
`ifdef TIMER_CTRL_PAUSE_EN
  input  logic                      pause_i,
`endif
  input  logic [COUNTER_WIDTH-1:0]  period_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      busy_o,
  output logic                      tick_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [COUNTER_WIDTH-1:0]  count_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [COUNTER_WIDTH-1:0]  count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      mode_q, mode_d;
  logic [COUNTER_WIDTH-1:0]  period_q, period_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      busy_q, busy_d;
  logic                      tick_q, tick_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic pause_w;
  logic step_w;
  logic terminal_w;

`ifdef TIMER_CTRL_PAUSE_EN
  assign pause_w = pause_i;
`else
  assign pause_w = 1'b0;
`endif

  // A step is the counter enable; the terminal step is the one that would
  // carry the count to period_q, so the count never exceeds period_q-1.
  assign step_w     = (presc_q == prescale_q);
  assign terminal_w = step_w && (count_q == (period_q - COUNTER_WIDTH'(1)));

  // Next-state logic: sequencing, prescaler and main count.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    mode_d     = mode_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop_i blocks a coincident start (and suppresses the error pulse)
        if (start_i && !stop_i) begin
          if (period_i == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            mode_d     = mode_i;
            period_d   = period_i;
            prescale_d = prescale_i;
            count_d    = '0;
            presc_d    = '0;
          end
        end
      end

      ST_RUN: begin
        if (stop_i) begin
          // abort wins over a coincident terminal step: no tick, no done
          state_d = ST_IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (!pause_w) begin
          if (step_w) begin
            presc_d = '0;
            if (terminal_w) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (!mode_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              count_d = count_q + COUNTER_WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + PRESCALE_WIDTH'(1);
          end
        end
      end

      ST_DONE: begin
        // single cycle spent here while done_o is high; start_i is ignored
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        presc_d = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // State and registered outputs; async reset returns everything to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      busy_q     <= busy_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy_o  = busy_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule
